// File: rtl/uart_frame_demux.sv
// Splits a stream of 16-bit words into sync / data / checksum frames and
// presents the data fields on a flat bus once the checksum has been verified.
module uart_frame_demux #(
  parameter int          CHANNELS  = 4,
  parameter int          DATA_W    = 12,
  parameter logic [15:0] SYNC_WORD = 16'hA55A,
  parameter int          TIMEOUT   = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  word_in,
  input  logic                         word_valid,
  output logic [CHANNELS*DATA_W-1:0]   ch_data,
  output logic                         frame_valid,
  output logic                         frame_err,
  output logic [7:0]                   err_count
);

  localparam logic [3:0]  LAST_IDX   = 4'(CHANNELS - 1);
  localparam logic [19:0] TIMEOUT_M1 = 20'(TIMEOUT - 1);

  typedef enum logic [1:0] {HUNT, DATA, CHECK} state_t;

  state_t      state_reg;
  logic [3:0]  idx_reg;
  logic [15:0] sum_reg;
  logic [19:0] idle_reg;

  logic accept_data;
  logic load_frame;
  logic bad_frame;
  logic timeout_hit;
  logic error_event;

  assign accept_data = (state_reg == DATA) && word_valid;
  assign load_frame  = (state_reg == CHECK) && word_valid && (word_in == sum_reg);
  assign bad_frame   = (state_reg == CHECK) && word_valid && (word_in != sum_reg);
  // Fires on the idle clock that brings the counter up to TIMEOUT.
  assign timeout_hit = (state_reg != HUNT) && !word_valid && (idle_reg == TIMEOUT_M1);
  assign error_event = bad_frame || timeout_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= HUNT;
      idx_reg     <= '0;
      sum_reg     <= '0;
      idle_reg    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_valid <= load_frame;
      frame_err   <= error_event;
      if (error_event && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;

      case (state_reg)
        HUNT: begin
          if (word_valid && (word_in == SYNC_WORD)) begin
            state_reg <= DATA;
            idx_reg   <= '0;
            sum_reg   <= '0;
            idle_reg  <= '0;
          end
        end
        DATA: begin
          if (word_valid) begin
            sum_reg  <= sum_reg + word_in;
            idle_reg <= '0;
            idx_reg  <= idx_reg + 4'd1;
            if (idx_reg == LAST_IDX)
              state_reg <= CHECK;
          end else if (timeout_hit) begin
            state_reg <= HUNT;
            idle_reg  <= '0;
          end else begin
            idle_reg <= idle_reg + 20'd1;
          end
        end
        CHECK: begin
          if (word_valid || timeout_hit) begin
            state_reg <= HUNT;
            idle_reg  <= '0;
          end else begin
            idle_reg <= idle_reg + 20'd1;
          end
        end
        default: state_reg <= HUNT;
      endcase
    end
  end

  // Per-channel shadow field and output field; outputs change only on a verified frame.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [DATA_W-1:0] shadow_reg;
    logic [DATA_W-1:0] out_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        shadow_reg <= '0;
        out_reg    <= '0;
      end else begin
        if (accept_data && (idx_reg == 4'(gi)))
          shadow_reg <= word_in[DATA_W-1:0];
        if (load_frame)
          out_reg <= shadow_reg;
      end
    end

    assign ch_data[gi*DATA_W +: DATA_W] = out_reg;
  end

endmodule
